// File: rtl/jt9346_host_if.sv
// Command/response bus between a controller and the jt9346_host serial EEPROM master.
//   cmd_valid/cmd_ready : command handshake; cmd_op, cmd_addr, cmd_din are the payload
//   rsp_valid           : one-cycle completion pulse; rsp_dout, rsp_err qualify it
// master drives commands, slave (jt9346_host) answers.
interface jt9346_host_if #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 16
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_din;
  logic          rsp_valid;
  logic [DW-1:0] rsp_dout;
  logic          rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_din,
    input  cmd_ready, rsp_valid, rsp_dout, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_din,
    output cmd_ready, rsp_valid, rsp_dout, rsp_err
  );
endinterface

// File: rtl/jt9346_host.sv
// Host-side master for 93C46-style Microwire serial EEPROMs.
// Ports:
//   clk, rst_n : single rising-edge clock, asynchronous active-low reset
//   bus        : jt9346_host_if.slave command/response bus
//   scs        : EEPROM chip select (active high)
//   sclk       : EEPROM serial clock, CLKDIV clk cycles per half-period
//   sdi        : serial data towards the EEPROM
//   sdo        : serial data / ready-busy from the EEPROM (sampled directly)
module jt9346_host #(
  parameter int unsigned AW     = 6,
  parameter int unsigned DW     = 16,
  parameter int unsigned CLKDIV = 4,
  parameter int unsigned TOUT   = 65535
) (
  input  logic           clk,
  input  logic           rst_n,
  jt9346_host_if.slave   bus,
  output logic           scs,
  output logic           sclk,
  output logic           sdi,
  input  logic           sdo
);

  localparam int unsigned SLOT = 2 * CLKDIV;
  localparam int unsigned CW   = $clog2(SLOT + 1);
  localparam int unsigned TXW  = AW + 3 + DW;
  localparam int unsigned BW   = $clog2(TXW + 1);

  localparam logic [CW-1:0] CNT_RISE   = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] CNT_END    = CW'(SLOT - 1);
  localparam logic [CW-1:0] CNT_PRE    = CW'(CLKDIV);
  localparam logic [BW-1:0] SEND_BITS  = BW'(AW + 3);
  localparam logic [BW-1:0] DATA_BITS  = BW'(DW);
  localparam logic [15:0]   POLL_START = 16'(SLOT);
  localparam logic [15:0]   POLL_LAST  = 16'(TOUT - 1);

  typedef enum logic [2:0] {
    IDLE, SEND, WDATA, RDATA, CSGAP, POLL, DONE
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [BW-1:0]  bit_q;
  logic           pre_q;
  logic [TXW-1:0] tx_q;
  logic [DW-1:0]  rd_q;
  logic [1:0]     op_q;
  logic [1:0]     ext_q;
  logic           err_q;
  logic [15:0]    poll_q;
  logic           scs_q;
  logic           sclk_q;
  logic           sdi_q;
  logic           ready_q;
  logic           rsp_valid_q;
  logic           rsp_err_q;
  logic [DW-1:0]  rsp_dout_q;

  logic [TXW-1:0] tx_d;
  logic [15:0]    poll_d;
  logic           slot_rise;
  logic           slot_end;
  logic           last_bit;
  logic           is_read;
  logic           to_wdata;
  logic           to_csgap;

  // Slot position decode and command class after the opcode is sent
  assign tx_d      = {tx_q[TXW-2:0], 1'b0};
  assign poll_d    = (poll_q == 16'hFFFF) ? poll_q : poll_q + 16'd1;
  assign slot_rise = (cnt_q == CNT_RISE);
  assign slot_end  = (cnt_q == CNT_END);
  assign last_bit  = (bit_q == BW'(1));
  assign is_read   = (op_q == 2'b10);
  assign to_wdata  = (op_q == 2'b01) || ((op_q == 2'b00) && (ext_q == 2'b01));
  assign to_csgap  = (op_q == 2'b11) || ((op_q == 2'b00) && (ext_q == 2'b10));

  // Sequencer: all outputs come straight from registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      pre_q       <= 1'b0;
      tx_q        <= '0;
      rd_q        <= '0;
      op_q        <= 2'b00;
      ext_q       <= 2'b00;
      err_q       <= 1'b0;
      poll_q      <= '0;
      scs_q       <= 1'b0;
      sclk_q      <= 1'b0;
      sdi_q       <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dout_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!ready_q) begin
            ready_q <= 1'b1;
          end else if (bus.cmd_valid) begin
            // Preamble: start mid-slot with sclk held low so scs leads the first rise by one slot
            ready_q <= 1'b0;
            op_q    <= bus.cmd_op;
            ext_q   <= bus.cmd_addr[AW-1 -: 2];
            tx_q    <= {1'b1, bus.cmd_op, bus.cmd_addr, bus.cmd_din};
            bit_q   <= SEND_BITS;
            pre_q   <= 1'b1;
            cnt_q   <= CNT_PRE;
            err_q   <= 1'b0;
            scs_q   <= 1'b1;
            state_q <= SEND;
          end
        end

        SEND: begin
          cnt_q <= cnt_q + CW'(1);
          if (slot_rise && !pre_q) sclk_q <= 1'b1;
          if (slot_end) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
            pre_q  <= 1'b0;
            if (pre_q || !last_bit) begin
              sdi_q <= tx_q[TXW-1];
              tx_q  <= tx_d;
              if (!pre_q) bit_q <= bit_q - BW'(1);
            end else if (is_read) begin
              sdi_q   <= 1'b0;
              bit_q   <= DATA_BITS;
              state_q <= RDATA;
            end else if (to_wdata) begin
              // Data word follows the address directly in the shift register
              sdi_q   <= tx_q[TXW-1];
              tx_q    <= tx_d;
              bit_q   <= DATA_BITS;
              state_q <= WDATA;
            end else if (to_csgap) begin
              sdi_q   <= 1'b0;
              scs_q   <= 1'b0;
              state_q <= CSGAP;
            end else begin
              sdi_q   <= 1'b0;
              scs_q   <= 1'b0;
              state_q <= DONE;
            end
          end
        end

        WDATA: begin
          cnt_q <= cnt_q + CW'(1);
          if (slot_rise) sclk_q <= 1'b1;
          if (slot_end) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
            if (!last_bit) begin
              sdi_q <= tx_q[TXW-1];
              tx_q  <= tx_d;
              bit_q <= bit_q - BW'(1);
            end else begin
              sdi_q   <= 1'b0;
              scs_q   <= 1'b0;
              state_q <= CSGAP;
            end
          end
        end

        RDATA: begin
          cnt_q <= cnt_q + CW'(1);
          if (slot_rise) sclk_q <= 1'b1;
          if (slot_end) begin
            // Sample on the falling edge; first sample ends up in the MSB
            cnt_q  <= '0;
            sclk_q <= 1'b0;
            rd_q   <= DW'({rd_q, sdo});
            if (!last_bit) begin
              bit_q <= bit_q - BW'(1);
            end else begin
              scs_q   <= 1'b0;
              state_q <= DONE;
            end
          end
        end

        CSGAP: begin
          cnt_q <= cnt_q + CW'(1);
          if (slot_end) begin
            cnt_q   <= '0;
            scs_q   <= 1'b1;
            poll_q  <= '0;
            state_q <= POLL;
          end
        end

        POLL: begin
          // Ready/busy ignored until the EEPROM has had a full slot to drive it
          if ((poll_q >= POLL_START) && sdo) begin
            scs_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= DONE;
          end else if (poll_q >= POLL_LAST) begin
            scs_q   <= 1'b0;
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= DONE;
          end else begin
            poll_q <= poll_d;
          end
        end

        DONE: begin
          cnt_q <= cnt_q + CW'(1);
          if (slot_end) begin
            cnt_q       <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            if (is_read) rsp_dout_q <= rd_q;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign scs           = scs_q;
  assign sclk          = sclk_q;
  assign sdi           = sdi_q;
  assign bus.cmd_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_dout  = rsp_dout_q;

endmodule

// File: tb/tb_jt9346_host.sv
// Bench for jt9346_host paired with a behavioural 93C46-style EEPROM (AW=6, DW=16, CLKDIV=4).
module tb_jt9346_host;
  localparam int unsigned AW = 6, DW = 16, CLKDIV = 4, TOUT = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scs, sclk, sdi, sdo;

  jt9346_host_if #(.AW(AW), .DW(DW)) bus ();

  jt9346_host #(.AW(AW), .DW(DW), .CLKDIV(CLKDIV), .TOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .scs(scs), .sclk(sclk), .sdi(sdi), .sdo(sdo)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // ---------------- EEPROM model ----------------
  logic [15:0] mem [64];
  logic        mdl_init = 1'b0;
  logic        ewen = 1'b0;
  logic        scs_d = 1'b0, sclk_d = 1'b0;
  logic        started = 1'b0;
  int          nafter = 0;
  logic [31:0] sh = '0;
  logic [1:0]  cop = '0;
  logic [5:0]  cadr = '0;
  logic        rd_mode = 1'b0;
  logic [15:0] rd_data = '0;
  int          rd_idx = 0;
  logic        rbit = 1'b0;
  int          busy_cnt = 0;
  logic        force_busy = 1'b0;
  logic [31:0] nsh;

  assign nsh = {sh[30:0], sdi};
  assign sdo = force_busy ? 1'b0 : (scs ? (rd_mode ? rbit : (busy_cnt == 0)) : 1'b0);

  always @(posedge clk) begin
    scs_d  <= scs;
    sclk_d <= sclk;
    if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (!mdl_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'hFFFF;
      mdl_init <= 1'b1;
    end else if (scs_d && !scs) begin
      if (started && nafter >= 8) begin
        case (cop)
          2'b01: if (ewen && nafter == 24) begin mem[cadr] <= sh[15:0]; busy_cnt <= 30; end
          2'b11: if (ewen && nafter == 8) begin mem[cadr] <= 16'hFFFF; busy_cnt <= 30; end
          2'b00: begin
            case (cadr[5:4])
              2'b11: ewen <= 1'b1;
              2'b00: ewen <= 1'b0;
              2'b10: if (ewen && nafter == 8) begin
                for (int i = 0; i < 64; i++) mem[i] <= 16'hFFFF;
                busy_cnt <= 30;
              end
              default: if (ewen && nafter == 24) begin
                for (int i = 0; i < 64; i++) mem[i] <= sh[15:0];
                busy_cnt <= 30;
              end
            endcase
          end
          default: ;
        endcase
      end
      started <= 1'b0;
      nafter  <= 0;
      rd_mode <= 1'b0;
    end else if (scs && sclk && !sclk_d) begin
      if (!started) begin
        if (sdi) started <= 1'b1;
      end else begin
        sh     <= nsh;
        nafter <= nafter + 1;
        if (nafter == 7) begin
          cop  <= nsh[7:6];
          cadr <= nsh[5:0];
          if (nsh[7:6] == 2'b10) begin
            rd_mode <= 1'b1;
            rd_data <= mem[nsh[5:0]];
            rd_idx  <= 0;
            rbit    <= 1'b0;
          end
        end else if (rd_mode && rd_idx < 16) begin
          rbit   <= rd_data[15 - rd_idx];
          rd_idx <= rd_idx + 1;
        end
      end
    end
  end

  // ---------------- protocol watcher / scs window logger ----------------
  logic        p_sclk = 1'b0, p_sdi = 1'b0, p_scs = 1'b0;
  int          win_len = 0, win_rises = 0;
  logic [31:0] win_bits = '0;
  int          last_len = 0, last_rises = 0;
  logic [31:0] last_bits = '0;

  always @(negedge clk) begin
    p_sclk <= sclk;
    p_sdi  <= sdi;
    p_scs  <= scs;
    if (sclk) begin
      check("scs_high_while_sclk", scs, 1'b1);
      if (p_sclk) check("sdi_stable_sclk_high", sdi, p_sdi);
    end
    if (scs && !p_scs) begin
      win_len   <= 1;
      win_rises <= 0;
      win_bits  <= '0;
    end else if (scs) begin
      win_len <= win_len + 1;
      if (sclk && !p_sclk) begin
        win_bits  <= {win_bits[30:0], sdi};
        win_rises <= win_rises + 1;
      end
    end else if (p_scs) begin
      last_len   <= win_len;
      last_rises <= win_rises;
      last_bits  <= win_bits;
    end
  end

  // ---------------- scoreboard monitor ----------------
  typedef struct packed {
    logic [15:0] dout;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   n_rsp = 0;
  int   n_rv = 0;
  logic p_rv = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    p_rv <= bus.rsp_valid;
    if (bus.rsp_valid) begin
      n_rv++;
      check("rsp_single_cycle", p_rv, 1'b0);
      check("rsp_scs_low", scs, 1'b0);
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_unexpected: actual rsp_valid=1 required no response");
      end else begin
        e = sbq.pop_front();
        check("rsp_dout", bus.rsp_dout, e.dout);
        check("rsp_err", bus.rsp_err, e.err);
        n_rsp++;
      end
    end
  end

  // ---------------- driver ----------------
  int n_cmds = 0;

  task automatic wait_ready();
    int k = 0;
    while (!bus.cmd_ready && k < 200) begin @(negedge clk); k++; end
    check("ready_before_cmd", bus.cmd_ready, 1'b1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] addr, input logic [15:0] din);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_addr  = addr;
    bus.cmd_din   = din;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("ready_drop_after_accept", bus.cmd_ready, 1'b0);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [5:0] addr, input logic [15:0] din,
                        input logic [15:0] exp_dout, input logic exp_err);
    int k = 0;
    int target;
    wait_ready();
    @(negedge clk);
    sbq.push_back('{dout: exp_dout, err: exp_err});
    target = n_rsp + 1;
    n_cmds++;
    issue(op, addr, din);
    while (n_rsp < target && k < 2000) begin @(negedge clk); k++; end
    if (n_rsp < target) begin
      n_chk++;
      n_fail++;
      $display("FAIL rsp_timeout: actual no rsp_valid after %0d cycles required one", k);
      sbq.delete();
    end
    @(posedge clk);
    #1;
    check("ready_return", bus.cmd_ready, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    int k;
    int nrv0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_addr  = '0;
    bus.cmd_din   = '0;

    repeat (3) @(negedge clk);
    check("rst_scs", scs, 1'b0);
    check("rst_sclk", sclk, 1'b0);
    check("rst_sdi", sdi, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    check("rst_rsp_dout", bus.rsp_dout, 16'h0000);
    check("rst_cmd_ready", bus.cmd_ready, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", bus.cmd_ready, 1'b1);
    @(negedge clk);

    // READ 0x2A: 9 command bits 1,1,0,1,0,1,0,1,0 then 16 read pulses with sdi low
    do_cmd(2'b10, 6'h2A, 16'h0000, 16'hFFFF, 1'b0);
    check("read2a_rises", last_rises, 25);
    check("read2a_bits", last_bits, 32'h01AA_0000);

    do_cmd(2'b10, 6'h3F, 16'h0000, 16'hFFFF, 1'b0);
    do_cmd(2'b00, 6'h30, 16'h0000, 16'hFFFF, 1'b0);      // EWEN
    do_cmd(2'b01, 6'h05, 16'hA55A, 16'hFFFF, 1'b0);      // WRITE
    do_cmd(2'b10, 6'h05, 16'h0000, 16'hA55A, 1'b0);      // READ
    do_cmd(2'b00, 6'h10, 16'h1234, 16'hA55A, 1'b0);      // WRAL
    do_cmd(2'b10, 6'h00, 16'h0000, 16'h1234, 1'b0);
    do_cmd(2'b10, 6'h3F, 16'h0000, 16'h1234, 1'b0);
    do_cmd(2'b01, 6'h05, 16'hA55A, 16'h1234, 1'b0);      // restore 0x05

    // Abort a WRITE during data bit 7 with an asynchronous reset
    wait_ready();
    @(negedge clk);
    issue(2'b01, 6'h05, 16'h0F0F);
    k = 0;
    while (win_rises < 17 && k < 1000) begin @(negedge clk); k++; end
    check("abort_reached_bit7", (win_rises >= 17), 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_scs", scs, 1'b0);
    check("abort_sclk", sclk, 1'b0);
    check("abort_sdi", sdi, 1'b0);
    check("abort_rsp_valid", bus.rsp_valid, 1'b0);
    check("abort_rsp_dout", bus.rsp_dout, 16'h0000);
    check("abort_cmd_ready", bus.cmd_ready, 1'b0);
    nrv0 = n_rv;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("abort_no_rsp", n_rv, nrv0);

    do_cmd(2'b10, 6'h05, 16'h0000, 16'hA55A, 1'b0);

    // Busy never clears: poll times out after TOUT cycles with scs high
    force_busy = 1'b1;
    do_cmd(2'b01, 6'h07, 16'h0000, 16'hA55A, 1'b1);
    check("timeout_poll_len", (last_len >= 96 && last_len <= 104), 1'b1);
    check("timeout_scs_low", scs, 1'b0);
    force_busy = 1'b0;

    check("one_rsp_per_cmd", n_rv, n_cmds);
    check("scoreboard_empty", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jt9346_host.md
JT9346_HOST -- requirements
Module: jt9346_host

Interface
REQ-001 Parameter AW, default 6, EEPROM address width in bits.
REQ-002 Parameter DW, default 16, EEPROM data word width in bits.
REQ-003 Parameter CLKDIV, default 4, clk cycles per sclk half-period; values below 4 are unsupported.
REQ-004 Parameter TOUT, default 65535, clk cycles allowed for the busy poll before an error is flagged.
REQ-005 clk  input  1  system clock; the block uses one clock only, and all logic is on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 cmd_valid  input  1  command request.
REQ-008 cmd_ready  output  1  block is in IDLE and will accept a command.
REQ-009 cmd_op  input  2  10 READ, 01 WRITE, 11 ERASE, 00 extended.
REQ-010 cmd_addr  input  AW  word address; for op 00, bits [AW-1:AW-2] select 11 EWEN, 00 EWDS, 10 ERAL, 01 WRAL.
REQ-011 cmd_din  input  DW  write data for WRITE and WRAL.
REQ-012 rsp_valid  output  1  one-cycle pulse when a command completes.
REQ-013 rsp_dout  output  DW  read data; valid while rsp_valid is high after READ, otherwise holds its previous value.
REQ-014 rsp_err  output  1  qualifies rsp_valid; set when the busy poll timed out.
REQ-015 scs  output  1  EEPROM chip select, active high.
REQ-016 sclk  output  1  EEPROM serial clock.
REQ-017 sdi  output  1  serial data to the EEPROM.
REQ-018 sdo  input  1  serial data and ready/busy from the EEPROM; sampled directly, with no synchronizer.

Function
REQ-019 A command is accepted on any clk where cmd_valid and cmd_ready are both high; the block latches op, addr and din in that cycle.
REQ-020 cmd_ready SHALL drop on the cycle after acceptance and SHALL return high only after rsp_valid.
REQ-021 State machine states: IDLE, SEND, WDATA, RDATA, CSGAP, POLL, DONE.
REQ-022 Bit slot timing: sdi changes on the cycle sclk falls (or at slot start); sclk is low for CLKDIV cycles, then high for CLKDIV cycles.
REQ-023 Each slot ends on the cycle sclk returns low; sclk is 0 in every state other than SEND, WDATA and RDATA.
REQ-024 SEND: scs is set to 1 one full slot before the first sclk rise.
REQ-025 SEND then shifts AW+3 bits MSB first: start bit 1, op[1:0], addr[AW-1:0].
REQ-026 Transition out of SEND: READ goes to RDATA.
REQ-027 Transition out of SEND: WRITE and WRAL go to WDATA.
REQ-028 Transition out of SEND: ERASE and ERAL go to CSGAP.
REQ-029 Transition out of SEND: EWEN and EWDS go to DONE with scs cleared.
REQ-030 WDATA shifts DW bits of din, MSB first, then goes to CSGAP.
REQ-031 RDATA issues DW sclk pulses and samples sdo on the cycle sclk falls.
REQ-032 RDATA shifts the sampled bits into a register MSB first, so the first sample becomes rsp_dout[DW-1].
REQ-033 RDATA then clears scs and goes to DONE.
REQ-034 CSGAP holds scs at 0 for 2*CLKDIV cycles, then sets scs to 1 and goes to POLL.
REQ-035 POLL samples sdo every cycle starting 2*CLKDIV cycles after entry.
REQ-036 POLL exit on sdo=1: clear scs and go to DONE with err=0.
REQ-037 POLL exit on timeout: if sdo is still 0 after TOUT cycles, clear scs and go to DONE with err=1.
REQ-038 DONE holds scs low for 2*CLKDIV cycles, then pulses rsp_valid for one cycle and returns to IDLE.
REQ-039 sdi idles at 0.
REQ-040 cmd_valid is ignored while busy; no queueing.
REQ-041 The poll counter is 16 bits and saturates; it does not wrap.
REQ-042 No parity or address checking; EWEN state is not tracked by the block.

Reset
REQ-043 While rst_n is low: scs=0, sclk=0, sdi=0, rsp_valid=0, rsp_err=0, rsp_dout=0, cmd_ready=0, state=IDLE.
REQ-044 cmd_ready rises on the first clk after rst_n deasserts.
REQ-045 Reset mid-command aborts immediately: all outputs take their reset values asynchronously, and no rsp_valid is issued for the aborted command.

Verification
REQ-046 Bench pairs the block with the team's 93C46-compatible EEPROM model (AW=6, DW=16, CLKDIV=4).
REQ-047 EWEN (op 00, addr 6'h30) then WRITE addr 6'h05 din 16'hA55A, then READ 6'h05 -> rsp_dout=16'hA55A, rsp_err=0, exactly one rsp_valid per command.
REQ-048 READ of an unwritten address 6'h3F -> rsp_dout=16'hFFFF.
REQ-049 EWEN, WRAL din 16'h1234, then READ 6'h00 and READ 6'h3F -> both return 16'h1234.
REQ-050 WRITE with sdo forced to 0 and TOUT=100 -> rsp_err=1 about 100 cycles after POLL entry, scs=0, cmd_ready returns to 1.
REQ-051 Protocol check on SEND: scs must not fall while sclk=1.
REQ-052 Protocol check on SEND: sdi must be stable for the whole sclk-high phase.
REQ-053 Protocol check on SEND: READ 6'h2A must send exactly 9 sclk rises with the bit pattern 1,1,0,1,0,1,0,1,0.
REQ-054 Assert rst_n low mid-WDATA (bit 7) -> outputs take their reset values within the same cycle and no rsp_valid follows.
REQ-055 After the reset in REQ-054, a fresh READ of the same address still completes correctly.
